soft_rst_ctrl: RTL and testbench
================================

Name: soft_rst_ctrl

Overview:
- Produces the active-low soft-reset request consumed by the clock/reset system's soft-reset input (ANDed there with the key reset).
- Issues a reset pulse of fixed length for any of three causes:
  - a register-bank software request;
  - a debounced front-panel key;
  - loss of PLL lock, when lock monitoring is enabled.
- After each pulse it waits for lock to be stable again, then a guard window, before it accepts a new request.
- Runs on the 10 MHz system clock; records the last reset cause and a reset count for status readback.

Parameters:
HOLD_CYCLES, 1000, number of cycles o_fpgasoft_rst is held low per event (100 us at 10 MHz)
DEB_CYCLES, 200000, number of consecutive stable-low samples that qualify a key press (20 ms)
LOCK_WAIT, 100, number of consecutive locked cycles required before leaving WAIT_LOCK
LOCK_TO, 65535, WAIT_LOCK timeout in cycles
GUARD_CYCLES, 10000, post-reset window during which requests are ignored
CNT_W, 20, width of internal counters; must hold the maximum of all cycle parameters

Ports:
i_fpga_clk  in  1  system clock, 10 MHz
i_fpga_rst  in  1  reset, synchronous, active-high
i_soft_rst_req  in  1  single-cycle software reset request, synchronous to i_fpga_clk
i_key_n  in  1  raw front-panel key, active low, asynchronous
i_dcm_locked  in  1  PLL locked, asynchronous
i_lock_mon_en  in  1  1 = loss of lock triggers a reset (static)
o_fpgasoft_rst  out  1  soft-reset request, active low, registered
o_busy  out  1  1 whenever state != IDLE
o_rst_cause  out  2  last cause: 00 none, 01 software, 10 key, 11 lock loss
o_lock_timeout  out  1  sticky; set when WAIT_LOCK times out
o_rst_cnt  out  8  number of pulses issued; saturates at 255

Behaviour:
- Reset values: o_fpgasoft_rst=1, o_busy=0, o_rst_cause=00, o_lock_timeout=0, o_rst_cnt=0, state=IDLE. Synchronizers, debounce counter and lock-armed flag are cleared.
- Asserting i_fpga_rst mid-pulse releases o_fpgasoft_rst on the next edge.
- Input conditioning:
  - i_key_n and i_dcm_locked pass through 2-FF synchronizers.
  - Key debounce: a counter increments while key_sync=0 and clears when key_sync=1. key_evt is a one-cycle pulse when the counter reaches DEB_CYCLES; the counter then holds, so there is one event per press.
  - lock_armed is set the first cycle lock_sync=1. lock_evt = i_lock_mon_en & lock_armed & lock_sync falling edge (registered previous value).
- FSM, states IDLE / HOLD / WAIT_LOCK / GUARD:
  - IDLE: on any event, go to HOLD. On that edge: o_fpgasoft_rst<=0, o_rst_cause<=cause, o_rst_cnt+1 (saturating), counter cleared. Cause priority if events coincide: key > lock > software; only one pulse is issued.
  - HOLD: o_fpgasoft_rst stays low for exactly HOLD_CYCLES cycles, then rises, and the FSM enters WAIT_LOCK.
  - WAIT_LOCK: o_fpgasoft_rst=1. Counts consecutive lock_sync=1 cycles; a 0 restarts the count. When the count reaches LOCK_WAIT, go to GUARD. If LOCK_TO cycles elapse in this state first, set o_lock_timeout and go to GUARD.
  - GUARD: lasts GUARD_CYCLES cycles, then IDLE.
- Events arriving in HOLD, WAIT_LOCK or GUARD are discarded, not queued:
  - Software pulses are lost.
  - A key press still held when IDLE is re-entered does not retrigger; a release and new press is required.
  - Lock falling edges inside these states are ignored.
- Latency from event to o_fpgasoft_rst low:
  - software request: 1 cycle;
  - lock loss: 4 cycles from the i_dcm_locked edge (2 sync + edge detect + output register);
  - key: 2 sync cycles + DEB_CYCLES + 1.
- o_busy is registered and asserts on the same edge o_fpgasoft_rst falls.
- Counters are CNT_W bits wide and never wrap inside a state.

Test Plan:
Bench overrides: HOLD=8, DEB=4, LOCK_WAIT=4, LOCK_TO=64, GUARD=16; i_dcm_locked=1 unless stated.
1. Software pulse at cycle 10 → o_fpgasoft_rst low for cycles 11-18 exactly; cause=01; cnt=1; o_busy falls 1+8+4+16 cycles after it rose (+sync offset).
2. Key held low 3 cycles, then 20 cycles → first press gives no reset. Second press gives one pulse, cause=10. Holding the key through GUARD gives no second pulse.
3. Monitor enabled, locked 1→0 in IDLE → pulse starts 4 cycles later, cause=11. Lock returns after 10 cycles → WAIT_LOCK exits after 4 stable cycles. o_lock_timeout=0.
4. Lock stays 0 after the pulse → WAIT_LOCK exits after 64 cycles; o_lock_timeout=1 until i_fpga_rst. Also: monitor disabled, lock drop → no pulse.
5. Key event and software request in the same cycle → one pulse, cause=10. Software request during HOLD or GUARD → ignored; cnt unchanged.
6. i_fpga_rst asserted in HOLD cycle 3 → next edge o_fpgasoft_rst=1, all outputs at reset values. 256 software resets → o_rst_cnt saturates at 255.

Source files
------------

// File: rtl/soft_rst_ctrl_if.sv
// soft_rst_ctrl_if: request inputs and status outputs
// of the soft-reset controller.
interface soft_rst_ctrl_if;
  logic       i_soft_rst_req;
  logic       i_key_n;
  logic       i_dcm_locked;
  logic       i_lock_mon_en;
  logic       o_fpgasoft_rst;
  logic       o_busy;
  logic [1:0] o_rst_cause;
  logic       o_lock_timeout;
  logic [7:0] o_rst_cnt;

  modport master (
    output i_soft_rst_req,
    output i_key_n,
    output i_dcm_locked,
    output i_lock_mon_en,
    input  o_fpgasoft_rst,
    input  o_busy,
    input  o_rst_cause,
    input  o_lock_timeout,
    input  o_rst_cnt
  );

  modport slave (
    input  i_soft_rst_req,
    input  i_key_n,
    input  i_dcm_locked,
    input  i_lock_mon_en,
    output o_fpgasoft_rst,
    output o_busy,
    output o_rst_cause,
    output o_lock_timeout,
    output o_rst_cnt
  );
endinterface

// File: rtl/soft_rst_ctrl.sv
// soft_rst_ctrl: fixed-length active-low soft-reset pulse
// from software, debounced key or PLL lock loss.
module soft_rst_ctrl #(
  parameter int HOLD_CYCLES  = 1000,
  parameter int DEB_CYCLES   = 200000,
  parameter int LOCK_WAIT    = 100,
  parameter int LOCK_TO      = 65535,
  parameter int GUARD_CYCLES = 10000,
  parameter int CNT_W        = 20
) (
  input logic            i_fpga_clk,
  input logic            i_fpga_rst,
  soft_rst_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    WAIT_LOCK,
    GUARD
  } state_t;

  localparam logic [1:0] C_SW   = 2'b01;
  localparam logic [1:0] C_KEY  = 2'b10;
  localparam logic [1:0] C_LOCK = 2'b11;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST =
    CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_MAX =
    CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] LOCK_OK =
    CNT_W'(LOCK_WAIT);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(LOCK_TO - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST =
    CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);

  logic             key_s1;
  logic             key_s2;
  logic             lock_s1;
  logic             lock_s2;
  logic             lock_prev;
  logic             lock_armed;
  logic             lock_evt;
  logic             key_evt;
  logic [CNT_W-1:0] deb_cnt;

  state_t           state;
  logic [CNT_W-1:0] tmr;
  logic [CNT_W-1:0] lock_run;
  logic [CNT_W-1:0] lock_run_nx;
  logic [1:0]       cause_nx;

  logic             rst_q;
  logic             busy_q;
  logic [1:0]       cause_q;
  logic             tmo_q;
  logic [7:0]       cnt_q;

  // key syncs park at the released level so reset
  // exit never looks like a press
  always_ff @(posedge i_fpga_clk) begin
    if (i_fpga_rst) begin
      key_s1     <= 1'b1;
      key_s2     <= 1'b1;
      lock_s1    <= 1'b0;
      lock_s2    <= 1'b0;
      lock_prev  <= 1'b0;
      lock_armed <= 1'b0;
      lock_evt   <= 1'b0;
      key_evt    <= 1'b0;
      deb_cnt    <= '0;
    end else begin
      key_s1     <= bus.i_key_n;
      key_s2     <= key_s1;
      lock_s1    <= bus.i_dcm_locked;
      lock_s2    <= lock_s1;
      lock_prev  <= lock_s2;
      lock_armed <= lock_armed | lock_s2;
      lock_evt   <= bus.i_lock_mon_en & lock_armed &
                    lock_prev & ~lock_s2;
      if (key_s2)
        deb_cnt <= '0;
      else if (deb_cnt != DEB_MAX)
        deb_cnt <= deb_cnt + ONE;
      key_evt <= ~key_s2 & (deb_cnt == DEB_LAST);
    end
  end

  always_comb begin
    cause_nx = 2'b00;
    if (key_evt)
      cause_nx = C_KEY;
    else if (lock_evt)
      cause_nx = C_LOCK;
    else if (bus.i_soft_rst_req)
      cause_nx = C_SW;
    lock_run_nx = lock_s2 ? lock_run + ONE : '0;
  end

  always_ff @(posedge i_fpga_clk) begin
    if (i_fpga_rst) begin
      state    <= IDLE;
      tmr      <= '0;
      lock_run <= '0;
      rst_q    <= 1'b1;
      busy_q   <= 1'b0;
      cause_q  <= 2'b00;
      tmo_q    <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cause_nx != 2'b00) begin
            state   <= HOLD;
            tmr     <= '0;
            rst_q   <= 1'b0;
            busy_q  <= 1'b1;
            cause_q <= cause_nx;
            if (cnt_q != 8'hFF)
              cnt_q <= cnt_q + 8'd1;
          end
        end
        HOLD: begin
          if (tmr == HOLD_LAST) begin
            state    <= WAIT_LOCK;
            tmr      <= '0;
            lock_run <= '0;
            rst_q    <= 1'b1;
          end else begin
            tmr <= tmr + ONE;
          end
        end
        WAIT_LOCK: begin
          lock_run <= lock_run_nx;
          tmr      <= tmr + ONE;
          if (lock_run_nx == LOCK_OK) begin
            state <= GUARD;
            tmr   <= '0;
          end else if (tmr == TO_LAST) begin
            state <= GUARD;
            tmr   <= '0;
            tmo_q <= 1'b1;
          end
        end
        GUARD: begin
          if (tmr == GUARD_LAST) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            tmr <= tmr + ONE;
          end
        end
      endcase
    end
  end

  assign bus.o_fpgasoft_rst = rst_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_rst_cause    = cause_q;
  assign bus.o_lock_timeout = tmo_q;
  assign bus.o_rst_cnt      = cnt_q;

endmodule

// File: tb/tb_soft_rst_ctrl.sv
// tb_soft_rst_ctrl: planned + random stimulus, timeline
// reference model, scoreboard of expected reset pulses.
module tb_soft_rst_ctrl;

  localparam int HOLD = 8;
  localparam int DEB  = 4;
  localparam int LW   = 4;
  localparam int TO   = 64;
  localparam int GRD  = 16;
  localparam int N    = 12600;

  logic clk = 1'b0;
  logic rst;

  soft_rst_ctrl_if bus ();

  soft_rst_ctrl #(
    .HOLD_CYCLES (HOLD),
    .DEB_CYCLES  (DEB),
    .LOCK_WAIT   (LW),
    .LOCK_TO     (TO),
    .GUARD_CYCLES(GRD),
    .CNT_W       (20)
  ) dut (
    .i_fpga_clk(clk),
    .i_fpga_rst(rst),
    .bus       (bus)
  );

  always #50 clk = ~clk;

  typedef struct {
    int start;
    int len;
    int cause;
    int cnt;
    int bend;
    int tmo;
  } exp_t;

  bit   rstp [N];
  bit   swp  [N];
  bit   keyp [N];
  bit   dcmp [N];
  bit   monp [N];

  bit   rst_e [N+2];
  bit   sw_e  [N+2];
  bit   key_e [N+2];
  bit   lock_e[N+2];
  bit   syl   [N+2];
  bit   syk   [N+2];
  int   runk  [N+2];

  exp_t exps[$];
  exp_t sb[$];
  int   ei = 0;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_seen = 0;

  function automatic void chk(string nm, int act,
                              int exp, int at);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at edge %0d",
               nm, act, exp, at);
    end
  endfunction

  task automatic key_press(input int at, input int len);
    for (int i = at; i < at + len && i < N; i++)
      keyp[i] = 1'b0;
  endtask

  task automatic lock_drop(input int at, input int len);
    for (int i = at; i < at + len && i < N; i++)
      dcmp[i] = 1'b0;
  endtask

  // Edge x samples plan cycle x-1; synchronized inputs
  // lag the raw plan by three edges after reset exit.
  task automatic run_model();
    int   r;
    int   free_at;
    int   cnt;
    int   tmo;
    int   c;
    bit   prevl;
    exp_t e;
    r = -100;
    rst_e[0] = 1'b1;
    syl[0] = 1'b0;
    runk[0] = 0;
    for (int x = 1; x <= N; x++) begin
      rst_e[x] = rstp[x-1];
      sw_e[x] = swp[x-1];
      if (rst_e[x]) r = x;
      syl[x] = (x <= r + 2) ? 1'b0 : dcmp[x-3];
      syk[x] = (x <= r + 2) ? 1'b1 : keyp[x-3];
      runk[x] = (rst_e[x] || syk[x]) ? 0 : runk[x-1] + 1;
      prevl = rst_e[x-1] ? 1'b0 : syl[x-1];
      key_e[x+1] = !rst_e[x] && runk[x] == DEB;
      lock_e[x+1] = !rst_e[x] && monp[x-1] &&
                    prevl && !syl[x];
    end
    free_at = 0;
    cnt = 0;
    tmo = 0;
    for (int x = 1; x <= N; x++) begin
      if (rst_e[x]) begin
        cnt = 0;
        tmo = 0;
        free_at = x;
        continue;
      end
      if (x <= free_at) continue;
      c = key_e[x] ? 2 : lock_e[x] ? 3 : sw_e[x] ? 1 : 0;
      if (c == 0) continue;
      cnt = (cnt < 255) ? cnt + 1 : 255;
      e.start = x;
      e.cause = c;
      e.cnt = cnt;
      e.len = HOLD;
      e.bend = -1;
      e.tmo = tmo;
      for (int y = x + 1; y <= x + HOLD && e.bend < 0; y++)
        if (rst_e[y]) begin
          e.len = y - x;
          e.bend = y;
          e.tmo = 0;
        end
      if (e.bend < 0) begin
        int w;
        int run;
        int g;
        w = x + HOLD;
        run = 0;
        g = -1;
        for (int y = w + 1; g < 0 && e.bend < 0; y++) begin
          if (rst_e[y]) begin
            e.bend = y;
            e.tmo = 0;
          end else begin
            run = syl[y] ? run + 1 : 0;
            if (run == LW) g = y;
            else if (y - w == TO) begin
              tmo = 1;
              g = y;
            end
          end
        end
        if (e.bend < 0) begin
          for (int y = g + 1; y <= g + GRD && e.bend < 0; y++)
            if (rst_e[y]) begin
              e.bend = y;
              e.tmo = 0;
            end
          if (e.bend < 0) begin
            e.bend = g + GRD;
            e.tmo = tmo;
          end
        end
      end
      free_at = e.bend;
      exps.push_back(e);
    end
  endtask

  task automatic drive(input int c);
    rst = rstp[c];
    bus.i_soft_rst_req = swp[c];
    bus.i_key_n = keyp[c];
    bus.i_dcm_locked = dcmp[c];
    bus.i_lock_mon_en = monp[c];
  endtask

  initial begin
    int t;
    int k;
    for (int c = 0; c < N; c++) begin
      rstp[c] = 1'b0;
      swp[c]  = 1'b0;
      keyp[c] = 1'b1;
      dcmp[c] = 1'b1;
      monp[c] = 1'b1;
    end
    for (int c = 0; c < 3; c++) rstp[c] = 1'b1;
    swp[10] = 1'b1;
    key_press(60, 3);
    key_press(70, 50);
    lock_drop(140, 10);
    lock_drop(200, 100);
    for (int c = 320; c < 360; c++) monp[c] = 1'b0;
    lock_drop(330, 10);
    key_press(380, 10);
    swp[386] = 1'b1;
    swp[390] = 1'b1;
    swp[410] = 1'b1;
    swp[440] = 1'b1;
    rstp[443] = 1'b1;
    for (int i = 0; i < 256; i++) swp[470 + 34*i] = 1'b1;
    t = 9200;
    while (t < 12100) begin
      k = $urandom_range(0, 3);
      case (k)
        0: swp[t] = 1'b1;
        1: key_press(t, $urandom_range(1, 12));
        2: lock_drop(t, $urandom_range(1, 90));
        default: begin
          key_press(t, $urandom_range(3, 6));
          swp[t + $urandom_range(0, 8)] = 1'b1;
        end
      endcase
      t += $urandom_range(2, 70);
    end
    rstp[12300] = 1'b1;
    run_model();

    drive(0);
    for (int c = 1; c < N; c++) begin
      @(posedge clk);
      #1;
      while (ei < exps.size() && exps[ei].start <= c + 1) begin
        sb.push_back(exps[ei]);
        ei++;
      end
      drive(c);
    end
    repeat (6) @(posedge clk);
    #10;
    chk("pending_pulses", sb.size() + exps.size() - ei, 0, N);
    chk("pulse_count", n_seen, exps.size(), N);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    int   x;
    bit   po;
    bit   pb;
    bit   have;
    exp_t cur;
    x = 0;
    po = 1'b1;
    pb = 1'b0;
    have = 1'b0;
    forever begin
      @(posedge clk);
      x++;
      @(negedge clk);
      if (x <= N && rst_e[x])
        chk("reset_state",
            int'({bus.o_fpgasoft_rst, bus.o_busy,
                  bus.o_rst_cause, bus.o_lock_timeout,
                  bus.o_rst_cnt}),
            int'(13'h1000), x);
      while (sb.size() > 0 && sb[0].start < x) begin
        chk("missing_pulse", 0, sb[0].start, x);
        void'(sb.pop_front());
      end
      if (po && bus.o_fpgasoft_rst !== 1'b1) begin
        n_seen++;
        if (sb.size() == 0) begin
          chk("unexpected_pulse", x, -1, x);
          have = 1'b0;
        end else begin
          cur = sb.pop_front();
          have = 1'b1;
          chk("pulse_start", x, cur.start, x);
          chk("cause", int'(bus.o_rst_cause), cur.cause, x);
          chk("rst_cnt", int'(bus.o_rst_cnt), cur.cnt, x);
          chk("busy_at_start", int'(bus.o_busy), 1, x);
        end
      end
      if (!po && bus.o_fpgasoft_rst === 1'b1 && have)
        chk("pulse_len", x - cur.start, cur.len, x);
      if (pb && bus.o_busy !== 1'b1 && have) begin
        chk("busy_end", x, cur.bend, x);
        chk("lock_timeout", int'(bus.o_lock_timeout),
            cur.tmo, x);
        have = 1'b0;
      end
      po = (bus.o_fpgasoft_rst === 1'b1);
      pb = (bus.o_busy === 1'b1);
    end
  end

endmodule
